// File: rtl/icap_ctrl_pkg.sv
// rtl/icap_ctrl_pkg.sv - shared state encoding, default width and byte bit-swap helper for the ICAP path
package icap_ctrl_pkg;

   localparam int ICAP_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_LAST  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } icap_state_t;

   // ICAP expects bit 0 of each configuration byte on the MSB of its byte lane.
   function automatic logic [7:0] bit_swap_byte(input logic [7:0] b);
      logic [7:0] r;
      for (int j = 0; j < 8; j++) begin
         r[j] = b[7-j];
      end
      return r;
   endfunction

endpackage

// File: rtl/icap_write_ctrl.sv
// rtl/icap_write_ctrl.sv - stream-to-ICAP write controller with hold register, completion pulse and busy timeout
module icap_write_ctrl
   import icap_ctrl_pkg::*;
#(
   parameter int   ICAP_WIDTH    = ICAP_WIDTH_DEFAULT,
   parameter logic IS_BUSY       = 1'b0,
   parameter int   BIT_SWAP      = 1,
   parameter int   TIMEOUT_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [ICAP_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  ICAP_CE,
   output logic                  ICAP_WRITE,
   output logic [ICAP_WIDTH-1:0] ICAP_I,
   input  logic                  ICAP_BUSY,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           word_count
);

   localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

   icap_state_t               state;
   icap_state_t               state_next;
   logic                      hold_vld;
   logic [ICAP_WIDTH-1:0]     hold_data;
   logic [ICAP_WIDTH-1:0]     data_out;
   logic [TIMEOUT_WIDTH-1:0]  timeout_cnt;
   logic                      accept;
   logic                      busy_cycle;
   logic                      beat;
   logic                      timeout_hit;

   assign accept      = hold_vld & (ICAP_BUSY != IS_BUSY);
   assign busy_cycle  = hold_vld & (ICAP_BUSY == IS_BUSY);
   assign beat        = s_valid & s_ready;
   // Fires on the edge where the counter would reach its all-ones limit.
   assign timeout_hit = busy_cycle & (timeout_cnt == TO_LIMIT);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (beat) state_next = s_last ? ST_LAST : ST_WRITE;
         ST_WRITE: if (beat && s_last) state_next = ST_LAST;
         ST_LAST:  if (accept) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         ST_ERROR: state_next = ST_ERROR;
         default:  state_next = ST_IDLE;
      endcase
      if (timeout_hit) begin
         state_next = ST_ERROR;
      end
   end

   always_comb begin
      s_ready = 1'b0;
      done    = 1'b0;
      error   = 1'b0;
      case (state)
         ST_IDLE, ST_WRITE: s_ready = (~hold_vld | accept) & ~RESET;
         ST_DONE:           done    = 1'b1;
         ST_ERROR:          error   = 1'b1;
         default:           s_ready = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold_vld  <= 1'b0;
         hold_data <= '0;
      end else if (state == ST_ERROR || timeout_hit) begin
         hold_vld <= 1'b0;
      end else if (beat) begin
         hold_vld  <= 1'b1;
         hold_data <= s_data;
      end else if (accept) begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET || !busy_cycle) begin
         timeout_cnt <= '0;
      end else begin
         timeout_cnt <= timeout_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         word_count <= '0;
      end else if (beat && state == ST_IDLE) begin
         word_count <= {31'd0, accept};
      end else if (accept) begin
         word_count <= word_count + 32'd1;
      end
   end

   generate
      if (BIT_SWAP != 0) begin : g_swap
         for (genvar k = 0; k < ICAP_WIDTH / 8; k++) begin : g_byte
            assign data_out[8*k +: 8] = bit_swap_byte(hold_data[8*k +: 8]);
         end
      end else begin : g_pass
         assign data_out = hold_data;
      end
   endgenerate

   // Strobes come straight from hold_vld so they cannot glitch.
   assign ICAP_I     = data_out;
   assign ICAP_CE    = ~hold_vld;
   assign ICAP_WRITE = ~hold_vld;

endmodule
